// File: rtl/booth_wallace_mult32.sv
// booth_wallace_mult32: signed 32x32->64 multiplier, radix-4 Booth + 4:2 Wallace tree, registered output.
module booth2_encoder (
  input  logic [2:0] triple,
  output logic [2:0] weight
);
  always_comb
    weight = (triple == 3'b000 || triple == 3'b111) ? 3'b000 :
             (triple == 3'b011) ? 3'b010 :
             (triple == 3'b100) ? 3'b110 :
             triple[2] ? 3'b111 : 3'b001;
endmodule

module ppg #(
  parameter int SHIFT = 0
) (
  input  logic [31:0] b,
  input  logic [2:0]  weight,
  output logic [63:0] pp
);
  logic [33:0] b_sext, neg_b, sel;
  always_comb begin
    b_sext = {{2{b[31]}}, b};
    neg_b  = ~b_sext + 34'd1;
    sel    = (weight == 3'b001) ? b_sext :
             (weight == 3'b010) ? b_sext << 1 :
             (weight == 3'b111) ? neg_b :
             (weight == 3'b110) ? neg_b << 1 : 34'd0;
    pp     = {{30{sel[33]}}, sel} << SHIFT;
  end
endmodule

module compressor42 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] c,
  input  logic [63:0] d,
  output logic [63:0] e,
  output logic [63:0] f
);
  logic [63:0] s1, c1;
  always_comb begin
    s1 = a ^ b ^ c;
    c1 = {(a[62:0] & b[62:0]) | (a[62:0] & c[62:0]) | (b[62:0] & c[62:0]), 1'b0};
    e  = s1 ^ c1 ^ d;
    f  = {(s1[62:0] & c1[62:0]) | (s1[62:0] & d[62:0]) | (c1[62:0] & d[62:0]), 1'b0};
  end
endmodule

module booth_wallace_mult32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  output logic [63:0] result
);
  logic [32:0] a_ext;
  logic [2:0]  weight [16];
  logic [63:0] pp [16];
  logic [63:0] s1 [8];
  logic [63:0] s2 [4];
  logic [63:0] s3 [2];
  logic [63:0] sum;

  assign a_ext = {a, 1'b0};

  genvar i;
  generate
    for (i = 0; i < 16; i++) begin : g_pp
      booth2_encoder u_enc (.triple(a_ext[2*i+2:2*i]), .weight(weight[i]));
      ppg #(.SHIFT(2*i)) u_ppg (.b(b), .weight(weight[i]), .pp(pp[i]));
    end
    for (i = 0; i < 4; i++) begin : g_s1
      compressor42 u_c (.a(pp[4*i]), .b(pp[4*i+1]), .c(pp[4*i+2]), .d(pp[4*i+3]),
                        .e(s1[2*i]), .f(s1[2*i+1]));
    end
    for (i = 0; i < 2; i++) begin : g_s2
      compressor42 u_c (.a(s1[4*i]), .b(s1[4*i+1]), .c(s1[4*i+2]), .d(s1[4*i+3]),
                        .e(s2[2*i]), .f(s2[2*i+1]));
    end
  endgenerate

  compressor42 u_s3 (.a(s2[0]), .b(s2[1]), .c(s2[2]), .d(s2[3]), .e(s3[0]), .f(s3[1]));

  assign sum = s3[0] + s3[1];

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      result    <= 64'd0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) result <= sum;
      out_valid <= in_valid;
    end
endmodule

// File: tb/tb_booth_wallace_mult32.sv
// tb_booth_wallace_mult32: directed vectors, async reset, streaming and valid-gating checks.
module tb_booth_wallace_mult32;
  logic        clock = 0;
  logic        reset = 0;
  logic        in_valid = 0;
  logic [31:0] a = 0, b = 0;
  logic        out_valid;
  logic [63:0] result;
  int pass_cnt = 0, total = 0;

  booth_wallace_mult32 dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .a(a), .b(b), .out_valid(out_valid), .result(result)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic v, input logic [31:0] x, input logic [31:0] y);
    in_valid = v;
    a = x;
    b = y;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return longint'($signed(x)) * longint'($signed(y));
  endfunction

  initial begin
    vec_t vecs [12];
    logic [63:0] held;
    logic [31:0] x, y;
    vecs[0]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
    vecs[1]  = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
    vecs[2]  = '{32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000};
    vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
    vecs[4]  = '{32'h55555555, 32'h00000007, 64'h0000000255555553};
    vecs[5]  = '{32'hAAAAAAAA, 32'h00000001, 64'hFFFFFFFFAAAAAAAA};
    vecs[6]  = '{32'h33333333, 32'hFFFFFFFF, 64'hFFFFFFFFCCCCCCCD};
    vecs[7]  = '{32'h00000000, 32'h80000000, 64'h0000000000000000};
    vecs[8]  = '{32'h00000001, 32'h12345678, 64'h0000000012345678};
    vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000};
    vecs[10] = '{32'h00000003, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1};
    vecs[11] = '{32'hFFFFFFFE, 32'h00000064, 64'hFFFFFFFFFFFFFF38};

    #1 reset = 1;
    #1;
    check("reset_result", result, 64'd0);
    check("reset_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clock);
    #1 reset = 0;

    for (int i = 0; i < 12; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d", i), result, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
    end

    #2 reset = 1;
    #1;
    check("async_reset_result", result, 64'd0);
    check("async_reset_valid", {63'd0, out_valid}, 64'd0);
    step(1'b1, 32'd3, 32'hFFFFFFFB);
    check("held_in_reset", result, 64'd0);
    reset = 0;
    step(1'b1, 32'd3, 32'hFFFFFFFB);
    check("after_reset", result, 64'hFFFFFFFFFFFFFFF1);
    check("after_reset_valid", {63'd0, out_valid}, 64'd1);

    for (int i = 0; i < 10000; i++) begin
      x = $random;
      y = $random;
      step(1'b1, x, y);
      check("stream", result, ref_mul(x, y));
      check("stream_valid", {63'd0, out_valid}, 64'd1);
    end

    held = result;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, $random, $random);
      check("gap_valid", {63'd0, out_valid}, 64'd0);
      check("gap_hold", result, held);
    end
    for (int i = 0; i < 4; i++) begin
      x = $random;
      y = $random;
      step(1'b1, x, y);
      check("resume", result, ref_mul(x, y));
      check("resume_valid", {63'd0, out_valid}, 64'd1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/booth_wallace_mult32.md
# booth_wallace_mult32

Signed 32×32→64-bit multiplier: radix-4 Booth encoding of `a`, sixteen partial products, a three-level 4:2 compressor tree and a final carry-propagate add, with a registered output. It is the integer multiply datapath block. It accepts one operand pair per clock and returns the full two's-complement product one cycle later. Sub-blocks are `booth2_encoder`, `ppg` and `compressor42`.

## Interface
- No parameters.
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers immediately.
- `in_valid`  in  1  operands on `a`/`b` are valid this cycle.
- `a`  in  32  signed multiplicand (two's complement); Booth-encoded operand.
- `b`  in  32  signed multiplier (two's complement); partial-product source.
- `out_valid`  out  1  `result` holds a new product.
- `result`  out  64  signed product `a*b`, exact, registered.

## Operation
- **booth2_encoder** (×16). Digit i takes triple {a[2i+1], a[2i], a[2i-1]}, with a[-1]=0.
  - Digit map: 000/111→0, 001/010→+1, 011→+2, 100→−2, 101/110→−1.
  - `weight` is the digit as a 3-bit two's-complement value: 000, 001, 010, 110, 111.
- **ppg** (×16, shift parameter 2i).
  - b_sext = 34-bit sign extension of b; neg_b = ~b_sext+1, mod 2^34.
  - Select by digit: 0, b_sext, b_sext<<1, neg_b, or neg_b<<1, all within 34 bits.
  - Sign-extend the selection to 64 bits, then shift left by 2i.
  - Upper bits are truncated to 64.
- **compressor42**, on 64-bit vectors.
  - Inputs a,b,c,d; outputs e,f with e+f ≡ a+b+c+d (mod 2^64).
  - Built bitwise from two 3:2 full-adder rows; each carry vector is shifted left by 1 and bit 63 carry-out is discarded.
- **Tree**: stage1 has 4 compressors, pp[4k..4k+3] → 8 vectors. Stage2 has 2 compressors → 4. Stage3 has 1 compressor → 2.
- **Final sum**: the two remaining vectors are added mod 2^64.
- All arithmetic is modulo 2^64; the exact signed product always fits, so no overflow is possible.
- Datapath is combinational from `a`/`b` to the output register.

## Timing
- Latency is 1 cycle. A valid pair on edge N sets `result`=a*b and `out_valid`=1 after edge N.
- Throughput is one product per cycle, with no stall or backpressure.
- `in_valid`=0 at an edge: `out_valid` goes 0 and `result` holds its previous value.
- Reset asserted (asynchronously, including mid-operation): `result`=0 and `out_valid`=0 immediately. Any in-flight product is lost.
- Reset release: the first edge with `reset`=0 samples inputs normally.
- Back-to-back valid pairs each produce a result on consecutive cycles, in order.

## Test plan
- Reset: assert `reset` with arbitrary inputs → `result`=0, `out_valid`=0 without waiting for a clock edge. Deassert, then present a=3, b=−5 valid → next cycle `result`=0xFFFFFFFFFFFFFFF1.
- Extremes:
  - 0x7FFFFFFF×0x7FFFFFFF → 0x3FFFFFFF00000001.
  - 0x80000000×0x80000000 → 0x4000000000000000.
  - 0x80000000×0x00000001 → 0xFFFFFFFF80000000.
  - 0xFFFFFFFF×0xFFFFFFFF → 1.
- Booth digit coverage:
  - a=0x55555555 (all +1) × b=7 → 0x0000000255555553.
  - a=0xAAAAAAAA × b=1 → 0xFFFFFFFFAAAAAAAA.
  - a=0x33333333 × b=−1 → 0xFFFFFFFFCCCCCCCD.
- Zero and identity: a=0, b=0x80000000 → 0; a=1, b=0x12345678 → 0x0000000012345678.
- Streaming: 10,000 back-to-back random valid pairs (`$random`) → each `result` equals the signed 64-bit reference product one cycle later, in order, with `out_valid`=1.
- Valid gating: drop `in_valid` for 3 cycles mid-stream → `out_valid`=0 and `result` holds during the gap; results resume with correct values afterwards.
